execute_stage: RTL
==================

Name: execute_stage

Overview:
- EX stage of the 16-bit MIPS pipeline, directly upstream of the data-memory stage.
- Takes decoded operands and control from ID and performs the ALU operation, including an iterative 16-cycle multiplier.
- Registers the EX/MEM pipeline outputs: ans_ex (ALU result / memory address), DM_data, and the memory control bits consumed by the data-memory stage.
- Stalls upstream while a multi-cycle operation is in flight.

Parameters:
- WIDTH, 16, datapath width; only 16 is supported.
- MUL_CYCLES, 16, number of shift-add iterations; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  ID presents a valid instruction
- A  in  16  rs operand
- B  in  16  rt operand; also store data
- imm  in  16  sign-extended immediate
- imm_sel  in  1  1: operand2=imm, 0: operand2=B
- alu_op  in  4  operation code (see Behaviour)
- mem_rw_id  in  1  1=write, 0=read
- mem_en_id  in  1  memory access enable
- mem_mux_sel_id  in  1  1=writeback takes memory data
- wb_en_id  in  1  register writeback enable
- rd_id  in  3  destination register
- flush  in  1  squash the current/in-flight instruction
- stall  out  1  ID must hold its inputs
- ans_ex  out  16  registered result / memory address
- DM_data  out  16  registered store data (B)
- mem_rw_ex  out  1  registered mem_rw_id
- mem_en_ex  out  1  registered mem_en_id
- mem_mux_sel_dm  out  1  registered mem_mux_sel_id
- wb_en_ex  out  1  registered wb_en_id
- rd_ex  out  3  registered rd_id

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0, state to IDLE, iteration counter to 0.
  - stall=0 while reset is asserted.
  - Reset mid-multiply abandons the operation; no result is emitted.
- op2 = imm_sel ? imm : B.
- alu_op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLL A by op2[3:0], 7 SRL, 8 SRA.
  - 9 SLT signed (result 0x0001/0x0000), 10 SLTU.
  - 11 MUL (multi-cycle), 12 DIVQ, 13 DIVR (see Optional Feature).
  - 14–15 produce result 0.
- Arithmetic is modulo 2^16; no overflow flag or trap.
- MUL returns the low 16 bits of the product.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, single-cycle op:
  - When in_valid=1, all EX/MEM outputs load on the next rising edge (1-cycle latency).
  - When in_valid=0, a bubble loads: mem_en_ex=0, mem_rw_ex=0, wb_en_ex=0, mem_mux_sel_dm=0; ans_ex, DM_data, rd_ex hold.
- IDLE, MUL with in_valid=1:
  - stall=1 combinationally in the same cycle.
  - The edge captures A and op2 into internal registers, clears the accumulator, and moves to MUL.
  - The EX/MEM register loads a bubble.
- MUL state:
  - One shift-add iteration per clock; stall=1.
  - After MUL_CYCLES iterations, go to DONE.
  - The EX/MEM register keeps loading bubbles.
- DONE state:
  - stall=0.
  - The next edge loads ans_ex=product with the captured control bits, DM_data and rd_ex, and returns to IDLE.
  - ID advances on that same edge.
  - Issue-to-result latency is 18 edges; ans_ex is valid after edge E17 when issue is edge E0.
- Control capture: the control bits, B and rd_id are captured at issue. ID holds them stable under stall anyway; the captured copy is authoritative.
- flush=1:
  - The next edge loads a bubble and forces IDLE, aborting MUL/DIV/DONE.
  - stall deasserts combinationally while flush=1.
  - flush has priority over in_valid.
- No forwarding or hazard detection in this block.

Optional Feature:
- Macro: EXEC_DIV_EN.
- Defined:
  - alu_op 12/13 run an unsigned restoring divider, A/op2, in the DIV state with identical timing to MUL (16 iterations, then DONE).
  - 12 returns the quotient; 13 returns the remainder.
  - Divide by zero returns quotient 0xFFFF and remainder A, with the same latency.
- Undefined:
  - alu_op 12/13 are single-cycle ops with result 0x0000 and stall=0.
  - The DIV state and divider logic are absent.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-stream, release -> all outputs 0, stall=0; the first ADD A=0x0003, B=0x0004 gives ans_ex=0x0007 one edge later.
- Store path: alu_op=ADD, A=0x0010, imm=0x0004, imm_sel=1, B=0xBEEF, mem_en_id=1, mem_rw_id=1 -> after 1 edge ans_ex=0x0014, DM_data=0xBEEF, mem_en_ex=1, mem_rw_ex=1.
- ALU corners:
  - SUB 0x0000-0x0001 -> 0xFFFF.
  - SRA 0x8000 by 15 -> 0xFFFF.
  - SLT 0x8000,0x0001 -> 0x0001.
  - SLTU 0x8000,0x0001 -> 0x0000.
- MUL: A=0x0123, B=0x0045 (product 0x4E6F) issued at E0, followed by an ADD held by ID.
  - stall=1 from issue through E16.
  - Bubbles (mem_en_ex=0, wb_en_ex=0) on E0..E16.
  - ans_ex=0x4E6F after E17; the held ADD result follows after E18.
  - Also 0xFFFF*0xFFFF -> 0x0001.
- Flush: flush=1 at E5 of a MUL -> after E5 state IDLE, stall=0, bubble; no product ever appears on ans_ex.
- EXEC_DIV_EN:
  - DIVQ 0x0064/0x0007 -> 0x000E; DIVR -> 0x0002, both at 18-edge latency.
  - DIVQ by 0 -> 0xFFFF.
  - Without the macro, DIVQ -> 0x0000 in 1 cycle with stall=0.

Source files
------------

// File: rtl/execute_stage_if.sv
// ID -> EX -> MEM connection for the 16-bit MIPS execute stage: decoded operands and
// control arrive from ID; stall goes back to ID; the registered EX/MEM outputs go on to the memory stage.
interface execute_stage_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] imm;
   logic             imm_sel;
   logic [3:0]       alu_op;
   logic             mem_rw_id;
   logic             mem_en_id;
   logic             mem_mux_sel_id;
   logic             wb_en_id;
   logic [2:0]       rd_id;
   logic             flush;
   logic             stall;
   logic [WIDTH-1:0] ans_ex;
   logic [WIDTH-1:0] DM_data;
   logic             mem_rw_ex;
   logic             mem_en_ex;
   logic             mem_mux_sel_dm;
   logic             wb_en_ex;
   logic [2:0]       rd_ex;

   modport master (
      output in_valid, A, B, imm, imm_sel, alu_op, mem_rw_id, mem_en_id,
             mem_mux_sel_id, wb_en_id, rd_id, flush,
      input  stall, ans_ex, DM_data, mem_rw_ex, mem_en_ex, mem_mux_sel_dm,
             wb_en_ex, rd_ex
   );

   modport slave (
      input  in_valid, A, B, imm, imm_sel, alu_op, mem_rw_id, mem_en_id,
             mem_mux_sel_id, wb_en_id, rd_id, flush,
      output stall, ans_ex, DM_data, mem_rw_ex, mem_en_ex, mem_mux_sel_dm,
             wb_en_ex, rd_ex
   );
endinterface

// File: rtl/execute_stage.sv
// EX stage of the 16-bit MIPS pipeline: single-cycle ALU plus an iterative 16-step shift-add multiplier.
// Define EXEC_DIV_EN to add the unsigned restoring divider (alu_op 12 = quotient, 13 = remainder).
module execute_stage #(
   parameter int WIDTH      = 16,
   parameter int MUL_CYCLES = 16
) (
   input logic          clk,
   input logic          reset,
   execute_stage_if.slave ex
);
   localparam int CNT_W = $clog2(MUL_CYCLES);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOR  = 4'd5;
   localparam logic [3:0] OP_SLL  = 4'd6;
   localparam logic [3:0] OP_SRL  = 4'd7;
   localparam logic [3:0] OP_SRA  = 4'd8;
   localparam logic [3:0] OP_SLT  = 4'd9;
   localparam logic [3:0] OP_SLTU = 4'd10;
   localparam logic [3:0] OP_MUL  = 4'd11;
`ifdef EXEC_DIV_EN
   localparam logic [3:0] OP_DIVQ = 4'd12;
   localparam logic [3:0] OP_DIVR = 4'd13;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
`ifdef EXEC_DIV_EN
      S_DIV,
`endif
      S_DONE
   } state_t;

   state_t           state_p0, state_nx;
   logic [CNT_W-1:0] cnt_p0;
   logic [WIDTH-1:0] acc_p0, mcand_p0, mplier_p0, cap_b_p0;
   logic             cap_rw_p0, cap_en_p0, cap_sel_p0, cap_wb_p0;
   logic [2:0]       cap_rd_p0;
   logic [WIDTH-1:0] ans_p1, dm_p1;
   logic             rw_p1, en_p1, sel_p1, wb_p1;
   logic [2:0]       rd_p1;
   logic [WIDTH-1:0] op2, alu_res, done_res;
   logic             issue, stall_c, last_iter;
`ifdef EXEC_DIV_EN
   logic             cap_div_p0, cap_rem_p0;
   logic [WIDTH:0]   trial, diff;
`endif

   function automatic logic [WIDTH-1:0] alu_f(input logic [3:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      logic signed [WIDTH-1:0] sa, sb;
      logic [3:0]              sh;
      sa = a;
      sb = b;
      sh = b[3:0];
      case (op)
         OP_ADD:  alu_f = a + b;
         OP_SUB:  alu_f = a - b;
         OP_AND:  alu_f = a & b;
         OP_OR:   alu_f = a | b;
         OP_XOR:  alu_f = a ^ b;
         OP_NOR:  alu_f = ~(a | b);
         OP_SLL:  alu_f = a << sh;
         OP_SRL:  alu_f = a >> sh;
         OP_SRA:  alu_f = sa >>> sh;
         OP_SLT:  alu_f = {{(WIDTH-1){1'b0}}, (sa < sb)};
         OP_SLTU: alu_f = {{(WIDTH-1){1'b0}}, (a < b)};
         default: alu_f = '0;
      endcase
   endfunction

   assign op2       = ex.imm_sel ? ex.imm : ex.B;
   assign alu_res   = alu_f(ex.alu_op, ex.A, op2);
   assign last_iter = (cnt_p0 == CNT_W'(MUL_CYCLES - 1));
   assign ex.stall  = stall_c & reset;

`ifdef EXEC_DIV_EN
   // Restoring divide: the dividend shifts out of mcand's MSB while quotient bits shift in at the LSB.
   assign trial    = {acc_p0, mcand_p0[WIDTH-1]};
   assign diff     = trial - {1'b0, mplier_p0};
   assign done_res = cap_div_p0 ? (cap_rem_p0 ? acc_p0 : mcand_p0) : acc_p0;
`else
   assign done_res = acc_p0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_p0 <= S_IDLE;
      else        state_p0 <= state_nx;
   end

   always_comb begin
      state_nx = state_p0;
      stall_c  = 1'b0;
      issue    = 1'b0;
      case (state_p0)
         S_IDLE: begin
            if (ex.in_valid && ex.alu_op == OP_MUL) begin
               issue    = 1'b1;
               stall_c  = 1'b1;
               state_nx = S_MUL;
            end
`ifdef EXEC_DIV_EN
            else if (ex.in_valid && (ex.alu_op == OP_DIVQ || ex.alu_op == OP_DIVR)) begin
               issue    = 1'b1;
               stall_c  = 1'b1;
               state_nx = S_DIV;
            end
`endif
         end
         S_MUL: begin
            stall_c = 1'b1;
            if (last_iter) state_nx = S_DONE;
         end
`ifdef EXEC_DIV_EN
         S_DIV: begin
            stall_c = 1'b1;
            if (last_iter) state_nx = S_DONE;
         end
`endif
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      // Flush wins over everything, including a same-cycle issue.
      if (ex.flush) begin
         state_nx = S_IDLE;
         stall_c  = 1'b0;
         issue    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_p0 <= '0;
      else if (issue) cnt_p0 <= '0;
      else if (state_p0 != S_IDLE && state_p0 != S_DONE) cnt_p0 <= cnt_p0 + 1'b1;
   end

   // Stage p0: operand capture and one multiply/divide iteration per clock.
   always_ff @(posedge clk) begin
      case (state_p0)
         S_IDLE: begin
            if (issue) begin
               acc_p0     <= '0;
               mcand_p0   <= ex.A;
               mplier_p0  <= op2;
               cap_b_p0   <= ex.B;
               cap_rw_p0  <= ex.mem_rw_id;
               cap_en_p0  <= ex.mem_en_id;
               cap_sel_p0 <= ex.mem_mux_sel_id;
               cap_wb_p0  <= ex.wb_en_id;
               cap_rd_p0  <= ex.rd_id;
`ifdef EXEC_DIV_EN
               cap_div_p0 <= (ex.alu_op != OP_MUL);
               cap_rem_p0 <= (ex.alu_op == OP_DIVR);
`endif
            end
         end
         S_MUL: begin
            acc_p0    <= acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
            mcand_p0  <= mcand_p0 << 1;
            mplier_p0 <= mplier_p0 >> 1;
         end
`ifdef EXEC_DIV_EN
         S_DIV: begin
            if (!diff[WIDTH]) begin
               acc_p0   <= diff[WIDTH-1:0];
               mcand_p0 <= {mcand_p0[WIDTH-2:0], 1'b1};
            end else begin
               acc_p0   <= trial[WIDTH-1:0];
               mcand_p0 <= {mcand_p0[WIDTH-2:0], 1'b0};
            end
         end
`endif
         default: ;
      endcase
   end

   // Stage p1: EX/MEM pipeline register; any cycle without a result loads a bubble.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ans_p1 <= '0;
         dm_p1  <= '0;
         rd_p1  <= '0;
         rw_p1  <= 1'b0;
         en_p1  <= 1'b0;
         sel_p1 <= 1'b0;
         wb_p1  <= 1'b0;
      end else begin
         rw_p1  <= 1'b0;
         en_p1  <= 1'b0;
         sel_p1 <= 1'b0;
         wb_p1  <= 1'b0;
         if (!ex.flush) begin
            if (state_p0 == S_IDLE && ex.in_valid && !issue) begin
               ans_p1 <= alu_res;
               dm_p1  <= ex.B;
               rd_p1  <= ex.rd_id;
               rw_p1  <= ex.mem_rw_id;
               en_p1  <= ex.mem_en_id;
               sel_p1 <= ex.mem_mux_sel_id;
               wb_p1  <= ex.wb_en_id;
            end else if (state_p0 == S_DONE) begin
               ans_p1 <= done_res;
               dm_p1  <= cap_b_p0;
               rd_p1  <= cap_rd_p0;
               rw_p1  <= cap_rw_p0;
               en_p1  <= cap_en_p0;
               sel_p1 <= cap_sel_p0;
               wb_p1  <= cap_wb_p0;
            end
         end
      end
   end

   assign ex.ans_ex         = ans_p1;
   assign ex.DM_data        = dm_p1;
   assign ex.rd_ex          = rd_p1;
   assign ex.mem_rw_ex      = rw_p1;
   assign ex.mem_en_ex      = en_p1;
   assign ex.mem_mux_sel_dm = sel_p1;
   assign ex.wb_en_ex       = wb_p1;
endmodule
